// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto a single register-file
// write port with round-robin conflict resolution, and keeps a scoreboard of
// registers that have an issued but not yet written result.
module wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   // ALU result source
   input  logic            alu_valid_i,
   output logic            alu_ready_o,
   input  logic [4:0]      alu_rd_i,
   input  logic [XLEN-1:0] alu_data_i,
   // LSU result source
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [4:0]      lsu_rd_i,
   input  logic [XLEN-1:0] lsu_data_i,
   // issue side: marks a destination as pending
   input  logic            iss_valid_i,
   input  logic [4:0]      iss_rd_i,
   // register file write port
   output logic            we_o,
   output logic [4:0]      waddr_o,
   output logic [XLEN-1:0] wdata_o,
   // scoreboard
   output logic [31:0]     pending_o
);

   localparam int STAGES = 1;
   localparam int NREGS  = 32;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

   // which source won the most recent conflict
   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LSU = 1'b1
   } gnt_e;

   gnt_e             last_grant;
   wb_req_t          alu_req;
   wb_req_t          lsu_req;
   wb_req_t          sel_req;
   logic             grant_lsu;
   logic             conflict;
   logic             xfer;
   logic [STAGES:0]  vld_pipe;
   logic [NREGS-1:1] pending_q;
   logic [NREGS-1:1] set_vec;
   logic [NREGS-1:1] clr_vec;

   assign alu_req = '{rd: alu_rd_i, data: alu_data_i};
   assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};

   // Grant: a lone valid source wins outright; on conflict the source that
   // lost the previous conflict wins. Ready is purely combinational.
   always_comb begin
      conflict    = alu_valid_i & lsu_valid_i;
      grant_lsu   = lsu_valid_i & (~alu_valid_i | (last_grant == GNT_ALU));
      alu_ready_o = alu_valid_i & ~grant_lsu;
      lsu_ready_o = grant_lsu;
      xfer        = alu_ready_o | lsu_ready_o;
      sel_req     = grant_lsu ? lsu_req : alu_req;
      // x0 results complete the handshake but never reach the write port
      vld_pipe[0] = xfer & (sel_req.rd != 5'd0);
   end

   // Round-robin pointer only moves on conflict cycles, so a run of lone
   // grants from one source does not cost the other source its turn.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         last_grant <= GNT_ALU;
      else if (conflict)
         last_grant <= grant_lsu ? GNT_LSU : GNT_ALU;
   end

   // Registered write port; address/data hold when nothing is written so
   // the port does not toggle needlessly.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_pipe[STAGES:1] <= '0;
         waddr_o            <= '0;
         wdata_o            <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (vld_pipe[0]) begin
            waddr_o <= sel_req.rd;
            wdata_o <= sel_req.data;
         end
      end
   end

   assign we_o = vld_pipe[STAGES];

   // Per-register set/clear decode; x0 is never tracked.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 1; i < NREGS; i++) begin
         set_vec[i] = iss_valid_i && (iss_rd_i == 5'(i));
         clr_vec[i] = we_o && (waddr_o == 5'(i));
      end
   end

   // Scoreboard: a new issue to the same register beats the write that
   // retires the older result, so the younger producer stays visible.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         pending_q <= '0;
      else
         pending_q <= (pending_q & ~clr_vec) | set_vec;
   end

   assign pending_o = {pending_q, 1'b0};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, lone grants, round-robin conflicts,
// x0 discard, scoreboard set/clear, reset mid-write and sustained streaming.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] pending;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   wb_arbiter #(.XLEN(32)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .alu_valid_i (alu_valid),
      .alu_ready_o (alu_ready),
      .alu_rd_i    (alu_rd),
      .alu_data_i  (alu_data),
      .lsu_valid_i (lsu_valid),
      .lsu_ready_o (lsu_ready),
      .lsu_rd_i    (lsu_rd),
      .lsu_data_i  (lsu_data),
      .iss_valid_i (iss_valid),
      .iss_rd_i    (iss_rd),
      .we_o        (we),
      .waddr_o     (waddr),
      .wdata_o     (wdata),
      .pending_o   (pending)
   );

   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // short reset pulse entirely between two rising edges
   task automatic do_reset();
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      iss_valid = 1'b0;
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      #1;
      tot_cnt++; if (we !== 1'b0) $display("FAIL rst_we: got %b exp 0", we); else pass_cnt++;
      tot_cnt++; if (waddr !== 5'd0) $display("FAIL rst_waddr: got %0d exp 0", waddr); else pass_cnt++;
      tot_cnt++; if (wdata !== 32'h0) $display("FAIL rst_wdata: got %h exp 0", wdata); else pass_cnt++;
      tot_cnt++; if (pending !== 32'h0) $display("FAIL rst_pending: got %h exp 0", pending); else pass_cnt++;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b10) $display("FAIL rst_alu_only_ready: got %b exp 10", {alu_ready, lsu_ready}); else pass_cnt++;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b01) $display("FAIL rst_conflict_lsu_first: got %b exp 01", {alu_ready, lsu_ready}); else pass_cnt++;
      tick();
      tot_cnt++; if (we !== 1'b0) $display("FAIL rst_held_we: got %b exp 0", we); else pass_cnt++;
      alu_valid = 1'b0; lsu_valid = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic test_single_alu();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b10) $display("FAIL single_ready: got %b exp 10", {alu_ready, lsu_ready}); else pass_cnt++;
      tick();
      alu_valid = 1'b0;
      tot_cnt++; if (we !== 1'b1) $display("FAIL single_we: got %b exp 1", we); else pass_cnt++;
      tot_cnt++; if (waddr !== 5'd5) $display("FAIL single_waddr: got %0d exp 5", waddr); else pass_cnt++;
      tot_cnt++; if (wdata !== 32'hDEADBEEF) $display("FAIL single_wdata: got %h exp deadbeef", wdata); else pass_cnt++;
      tick();
      tot_cnt++; if (we !== 1'b0) $display("FAIL single_we_drop: got %b exp 0", we); else pass_cnt++;
      tot_cnt++; if ({waddr, wdata} !== {5'd5, 32'hDEADBEEF}) $display("FAIL single_hold: got %0d/%h exp 5/deadbeef", waddr, wdata); else pass_cnt++;
   endtask

   task automatic test_conflict();
      do_reset();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0003;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_0004;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b01) $display("FAIL conf1_ready: got %b exp 01", {alu_ready, lsu_ready}); else pass_cnt++;
      tick();
      lsu_data = 32'h4444_0044;  // next LSU result, same destination
      tot_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd4, 32'h4444_0004}) $display("FAIL conf1_write: got %b/%0d/%h exp 1/4/44440004", we, waddr, wdata); else pass_cnt++;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b10) $display("FAIL conf2_ready: got %b exp 10", {alu_ready, lsu_ready}); else pass_cnt++;
      tick();
      alu_valid = 1'b0;
      tot_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h3333_0003}) $display("FAIL conf2_write: got %b/%0d/%h exp 1/3/33330003", we, waddr, wdata); else pass_cnt++;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b01) $display("FAIL lone_lsu_ready: got %b exp 01", {alu_ready, lsu_ready}); else pass_cnt++;
      tick();
      // lone LSU grant above must not move the pointer: LSU wins again
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h6666_0006;
      lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h8888_0008;
      tot_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd4, 32'h4444_0044}) $display("FAIL lone_lsu_write: got %b/%0d/%h exp 1/4/44440044", we, waddr, wdata); else pass_cnt++;
      #1;
      tot_cnt++; if ({alu_ready, lsu_ready} !== 2'b01) $display("FAIL conf3_ready: got %b exp 01", {alu_ready, lsu_ready}); else pass_cnt++;
      tick();
      lsu_valid = 1'b0;
      tot_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd8, 32'h8888_0008}) $display("FAIL conf3_write: got %b/%0d/%h exp 1/8/88880008", we, waddr, wdata); else pass_cnt++;
      tick();
      alu_valid = 1'b0;
      tot_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd6, 32'h6666_0006}) $display("FAIL conf3_alu_write: got %b/%0d/%h exp 1/6/66660006", we, waddr, wdata); else pass_cnt++;
      tick();
      tot_cnt++; if (we !== 1'b0) $display("FAIL conf_idle_we: got %b exp 0", we); else pass_cnt++;
   endtask

   task automatic test_x0();
      do_reset();
      iss_valid = 1'b1; iss_rd = 5'd2;
      tick();
      iss_valid = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
      #1;
      tot_cnt++; if (lsu_ready !== 1'b1) $display("FAIL x0_ready: got %b exp 1", lsu_ready); else pass_cnt++;
      tick();
      lsu_valid = 1'b0;
      tot_cnt++; if (we !== 1'b0) $display("FAIL x0_we: got %b exp 0", we); else pass_cnt++;
      tot_cnt++; if (pending !== 32'h0000_0004) $display("FAIL x0_pending: got %h exp 00000004", pending); else pass_cnt++;
   endtask

   task automatic test_scoreboard();
      do_reset();
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0;
      tot_cnt++; if (pending !== 32'h80) $display("FAIL sb_set: got %h exp 80", pending); else pass_cnt++;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
      tick();
      alu_valid = 1'b0;
      tot_cnt++; if ({we, waddr} !== {1'b1, 5'd7}) $display("FAIL sb_write: got %b/%0d exp 1/7", we, waddr); else pass_cnt++;
      tot_cnt++; if (pending !== 32'h80) $display("FAIL sb_pend_in_we: got %h exp 80", pending); else pass_cnt++;
      tick();
      tot_cnt++; if (pending !== 32'h0) $display("FAIL sb_clear: got %h exp 0", pending); else pass_cnt++;
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7778;
      tick();
      alu_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;  // reissue in the write cycle
      tot_cnt++; if (we !== 1'b1) $display("FAIL sb_we2: got %b exp 1", we); else pass_cnt++;
      tick();
      iss_valid = 1'b0;
      tot_cnt++; if (pending !== 32'h80) $display("FAIL sb_set_wins: got %h exp 80", pending); else pass_cnt++;
      iss_valid = 1'b1; iss_rd = 5'd0;
      tick();
      iss_valid = 1'b0;
      tot_cnt++; if (pending !== 32'h80) $display("FAIL sb_x0_issue: got %h exp 80", pending); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999;
      tick();
      alu_valid = 1'b0;
      tot_cnt++; if ({we, waddr} !== {1'b1, 5'd9}) $display("FAIL mid_we_before: got %b/%0d exp 1/9", we, waddr); else pass_cnt++;
      rstn = 1'b0;
      #1;
      tot_cnt++; if (we !== 1'b0) $display("FAIL mid_we_reset: got %b exp 0", we); else pass_cnt++;
      tot_cnt++; if (pending !== 32'h0) $display("FAIL mid_pending_reset: got %h exp 0", pending); else pass_cnt++;
      tot_cnt++; if ({waddr, wdata} !== {5'd0, 32'h0}) $display("FAIL mid_port_reset: got %0d/%h exp 0/0", waddr, wdata); else pass_cnt++;
      #1 rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tot_cnt++; if (we !== 1'b0) $display("FAIL mid_no_replay[%0d]: got %b exp 0", k, we); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int          ai = 0;
      int          li = 0;
      int          wr_cnt = 0;
      logic [1:0]  exp_rdy;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + ai); alu_data = 32'hA000_0000 + 32'(ai);
         lsu_valid = 1'b1; lsu_rd = 5'(20 + li); lsu_data = 32'hB000_0000 + 32'(li);
         #1;
         // after reset LSU takes the first conflict, then strict alternation
         exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_rd   = (k % 2 == 0) ? lsu_rd : alu_rd;
         exp_data = (k % 2 == 0) ? lsu_data : alu_data;
         tot_cnt++; if ({alu_ready, lsu_ready} !== exp_rdy) $display("FAIL stream_ready[%0d]: got %b exp %b", k, {alu_ready, lsu_ready}, exp_rdy); else pass_cnt++;
         if (lsu_ready) li++;
         else if (alu_ready) ai++;
         tick();
         if (we) wr_cnt++;
         tot_cnt++; if ({we, waddr, wdata} !== {1'b1, exp_rd, exp_data}) $display("FAIL stream_write[%0d]: got %b/%0d/%h exp 1/%0d/%h", k, we, waddr, wdata, exp_rd, exp_data); else pass_cnt++;
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      tick();
      tot_cnt++; if (we !== 1'b0) $display("FAIL stream_end_we: got %b exp 0", we); else pass_cnt++;
      tot_cnt++; if ({ai, li, wr_cnt} !== {32'd5, 32'd5, 32'd10}) $display("FAIL stream_counts: got alu %0d lsu %0d writes %0d exp 5/5/10", ai, li, wr_cnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_conflict();
      test_x0();
      test_scoreboard();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
